// File: rtl/lru_alloc_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : lru_alloc_arbiter
//  Purpose  : Round-robin arbiter sharing one LRU age table between NUM_REQ
//             requesters. A sequential scan finds the oldest slot, which is
//             offered on a valid/ack handshake. A touch port refreshes ages
//             on hits.
//  Options  : LRU_ALLOC_PERF_EN adds the perf_*_cnt_o performance counters.
//  Revision : 1.0 - initial release
// ============================================================================
module lru_alloc_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int LENGTH  = 8,
    localparam int AW      = $clog2(LENGTH),
    localparam int RW      = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    input  logic               touch_v_i,
    input  logic [AW-1:0]      touch_idx_i,
    output logic               alloc_v_o,
    output logic [AW-1:0]      alloc_idx_o,
    output logic [RW-1:0]      alloc_req_o,
    input  logic               alloc_ack_i,
    output logic               busy_o
`ifdef LRU_ALLOC_PERF_EN
    ,
    output logic [31:0]        perf_alloc_cnt_o,
    output logic [31:0]        perf_wait_cnt_o,
    output logic [15:0]        perf_restart_cnt_o
`endif
);

    localparam logic [1:0]    c_st_idle   = 2'd0;
    localparam logic [1:0]    c_st_scan   = 2'd1;
    localparam logic [1:0]    c_st_offer  = 2'd2;
    localparam logic [AW-1:0] c_last_slot = AW'(LENGTH - 1);
    localparam logic [RW-1:0] c_last_req  = RW'(NUM_REQ - 1);

    logic [1:0]         r_state;
    logic [AW-1:0]      r_age [LENGTH];
    logic [AW-1:0]      r_scan;
    logic [AW-1:0]      r_best;
    logic [AW-1:0]      r_best_age;
    logic [RW-1:0]      r_win;
    logic [RW-1:0]      r_rr;
    logic [NUM_REQ-1:0] r_gnt;

    logic [RW-1:0]      w_win;
    logic               w_accept;
    logic               w_restart;

    assign w_accept  = (r_state == c_st_offer) && alloc_ack_i;
    // A touch invalidates the scan only if it hits the slot being compared
    // or the current best; at s=0 the best register is stale and ignored.
    assign w_restart = (r_state == c_st_scan) && touch_v_i &&
                       ((touch_idx_i == r_scan) ||
                        ((r_scan != '0) && (touch_idx_i == r_best)));

    // Round-robin pick: first requester at or after the pointer, wrapping
    always_comb begin : p_arb
        logic [RW-1:0] idx;
        idx   = '0;
        w_win = r_rr;
        // Walk offsets from far to near so the nearest set bit wins last
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = RW'((int'(r_rr) + k) % NUM_REQ);
            if (req_i[idx]) begin
                w_win = idx;
            end
        end
    end

    // Control FSM with the one-slot-per-cycle oldest-age scan
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_st_idle;
            r_scan     <= '0;
            r_best     <= '0;
            r_best_age <= '0;
            r_win      <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (|req_i) begin
                        r_win   <= w_win;
                        r_scan  <= '0;
                        r_state <= c_st_scan;
                    end
                end
                c_st_scan: begin
                    if (w_restart) begin
                        r_scan <= '0;
                    end else begin
                        // Strict compare keeps the lowest index on ties
                        if ((r_scan == '0) || (r_age[r_scan] > r_best_age)) begin
                            r_best     <= r_scan;
                            r_best_age <= r_age[r_scan];
                        end
                        if (r_scan == c_last_slot) begin
                            r_state <= c_st_offer;
                        end else begin
                            r_scan <= r_scan + AW'(1);
                        end
                    end
                end
                c_st_offer: begin
                    if (alloc_ack_i) begin
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // Age table: touches zero a slot, an accepted allocation ages everyone else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LENGTH; i++) begin
                r_age[i] <= AW'(i);
            end
        end else begin
            for (int i = 0; i < LENGTH; i++) begin
                if (touch_v_i && (touch_idx_i == AW'(i))) begin
                    r_age[i] <= '0;
                end else if (w_accept) begin
                    if (r_best == AW'(i)) begin
                        r_age[i] <= '0;
                    end else if (r_age[i] != c_last_slot) begin
                        r_age[i] <= r_age[i] + AW'(1);
                    end
                end
            end
        end
    end

    // Grant pulse and round-robin pointer advance on acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt <= '0;
            r_rr  <= '0;
        end else begin
            r_gnt <= '0;
            if (w_accept) begin
                r_gnt <= {{(NUM_REQ-1){1'b0}}, 1'b1} << r_win;
                r_rr  <= (r_win == c_last_req) ? '0 : r_win + RW'(1);
            end
        end
    end

    assign gnt_o       = r_gnt;
    assign alloc_v_o   = (r_state == c_st_offer);
    assign alloc_idx_o = r_best;
    assign alloc_req_o = r_win;
    assign busy_o      = (r_state != c_st_idle);

`ifdef LRU_ALLOC_PERF_EN
    logic [31:0] r_perf_alloc;
    logic [31:0] r_perf_wait;
    logic [15:0] r_perf_restart;

    // Free-running wrapping event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_alloc   <= '0;
            r_perf_wait    <= '0;
            r_perf_restart <= '0;
        end else begin
            if (w_accept) begin
                r_perf_alloc <= r_perf_alloc + 32'd1;
            end
            if ((r_state == c_st_offer) && !alloc_ack_i) begin
                r_perf_wait <= r_perf_wait + 32'd1;
            end
            if (w_restart) begin
                r_perf_restart <= r_perf_restart + 16'd1;
            end
        end
    end

    assign perf_alloc_cnt_o   = r_perf_alloc;
    assign perf_wait_cnt_o    = r_perf_wait;
    assign perf_restart_cnt_o = r_perf_restart;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lru_alloc_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lru_alloc_arbiter
//  Purpose  : Self-checking bench for lru_alloc_arbiter (NUM_REQ=4,
//             LENGTH=8) against a transaction-level LRU model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lru_alloc_arbiter;

    localparam int NUM_REQ = 4;
    localparam int LENGTH  = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_i;
    logic [3:0]   gnt_o;
    logic         touch_v_i;
    logic [2:0]   touch_idx_i;
    logic         alloc_v_o;
    logic [2:0]   alloc_idx_o;
    logic [1:0]   alloc_req_o;
    logic         alloc_ack_i;
    logic         busy_o;
`ifdef LRU_ALLOC_PERF_EN
    logic [31:0]  perf_alloc_cnt_o;
    logic [31:0]  perf_wait_cnt_o;
    logic [15:0]  perf_restart_cnt_o;
`endif

    lru_alloc_arbiter #(.NUM_REQ(NUM_REQ), .LENGTH(LENGTH)) u_dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .req_i              (req_i),
        .gnt_o              (gnt_o),
        .touch_v_i          (touch_v_i),
        .touch_idx_i        (touch_idx_i),
        .alloc_v_o          (alloc_v_o),
        .alloc_idx_o        (alloc_idx_o),
        .alloc_req_o        (alloc_req_o),
        .alloc_ack_i        (alloc_ack_i),
        .busy_o             (busy_o)
`ifdef LRU_ALLOC_PERF_EN
        ,
        .perf_alloc_cnt_o   (perf_alloc_cnt_o),
        .perf_wait_cnt_o    (perf_wait_cnt_o),
        .perf_restart_cnt_o (perf_restart_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: ages per slot, arbitration pointer, current victim
    int m_age [LENGTH];
    int m_rr;
    int m_vic;
    int m_allocs;
    int m_waits;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_victim();
        int best = 0;
        for (int i = 1; i < LENGTH; i++) begin
            if (m_age[i] > m_age[best]) best = i;
        end
        return best;
    endfunction

    function automatic int model_winner(input logic [3:0] mask);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (mask[(m_rr + k) % NUM_REQ]) return (m_rr + k) % NUM_REQ;
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < LENGTH; i++) m_age[i] = i;
        m_rr     = 0;
        m_vic    = 0;
        m_allocs = 0;
        m_waits  = 0;
    endtask

    // Advance one clock, applying the current inputs to the model first
    task automatic tick();
        if (alloc_v_o && alloc_ack_i) begin
            for (int i = 0; i < LENGTH; i++) begin
                if (i == m_vic || (touch_v_i && int'(touch_idx_i) == i)) m_age[i] = 0;
                else if (m_age[i] < LENGTH - 1) m_age[i] = m_age[i] + 1;
            end
            m_allocs++;
        end else begin
            if (alloc_v_o) m_waits++;
            if (touch_v_i) m_age[touch_idx_i] = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        req_i       = '0;
        touch_v_i   = 1'b0;
        touch_idx_i = '0;
        alloc_ack_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One full allocation: request, wait for offer, optional stall, ack
    task automatic do_alloc(input logic [3:0] mask, input bit hold_req, input bit rnd,
                            input int touch_at, input int touch_slot,
                            input bit ack_touch, input int ack_slot, output int lat);
        int win;
        int n;
        int dly;
        win         = model_winner(mask);
        req_i       = mask;
        touch_v_i   = 1'b0;
        alloc_ack_i = 1'b0;
        tick();
        n = 1;
        check("gnt_idle", gnt_o, 0);
        check("busy", busy_o, 1);
        if (!hold_req) req_i = '0;
        while (!alloc_v_o && n < 300) begin
            touch_v_i   = 1'b0;
            alloc_ack_i = 1'b0;
            if (n == touch_at) begin
                touch_v_i   = 1'b1;
                touch_idx_i = 3'(touch_slot);
            end else if (rnd && $urandom_range(7) == 0) begin
                touch_v_i   = 1'b1;
                touch_idx_i = 3'($urandom_range(LENGTH - 1));
            end
            if (rnd) alloc_ack_i = 1'($urandom_range(1));
            tick();
            n++;
        end
        lat = n;
        touch_v_i   = 1'b0;
        alloc_ack_i = 1'b0;
        check("offer_seen", alloc_v_o, 1);
        m_vic = model_victim();
        check("victim", alloc_idx_o, m_vic);
        check("alloc_req", alloc_req_o, win);
        dly = rnd ? int'($urandom_range(3)) : 0;
        for (int d = 0; d < dly; d++) begin
            touch_v_i   = 1'b1;
            touch_idx_i = ($urandom_range(1) == 0) ? 3'(m_vic) : 3'($urandom_range(LENGTH - 1));
            tick();
            check("idx_stable", alloc_idx_o, m_vic);
        end
        touch_v_i   = ack_touch;
        touch_idx_i = 3'(ack_slot);
        alloc_ack_i = 1'b1;
        tick();
        touch_v_i   = 1'b0;
        alloc_ack_i = 1'b0;
        check("gnt", gnt_o, 32'd1 << win);
        check("alloc_v_drop", alloc_v_o, 0);
        check("busy_drop", busy_o, 0);
        m_rr = (win + 1) % NUM_REQ;
    endtask

    initial begin : p_watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin : p_main
        int lat;
        do_reset();
        check("rst_gnt", gnt_o, 0);
        check("rst_alloc_v", alloc_v_o, 0);
        check("rst_alloc_idx", alloc_idx_o, 0);
        check("rst_alloc_req", alloc_req_o, 0);
        check("rst_busy", busy_o, 0);

        // First allocation from reset: slot 7, requester 0, offer at cycle 9
        do_alloc(4'b0001, 1'b0, 1'b0, -1, 0, 1'b0, 0, lat);
        check("t1_latency", lat, 9);
        check("t1_idx", alloc_idx_o, 7);

        // All requesters held: grants rotate 0,1,2,3,0 with victims 7..3
        do_reset();
        for (int a = 0; a < 5; a++) begin
            do_alloc(4'b1111, 1'b1, 1'b0, -1, 0, 1'b0, 0, lat);
            check("t2_victim", m_vic, 7 - a);
        end

        // Touch of the last compared slot in the final scan cycle restarts
        do_reset();
        do_alloc(4'b0010, 1'b0, 1'b0, 8, 7, 1'b0, 0, lat);
        check("t3_latency", lat, 17);
        check("t3_victim", m_vic, 6);
`ifdef LRU_ALLOC_PERF_EN
        check("t3_restarts", perf_restart_cnt_o, 1);
`endif

        // Ack together with a touch of slot 3
        do_reset();
        do_alloc(4'b0001, 1'b0, 1'b0, -1, 0, 1'b1, 3, lat);
        do_alloc(4'b0100, 1'b0, 1'b0, -1, 0, 1'b0, 0, lat);
        check("t4_next_victim", m_vic, 6);

        // Touch every slot in order, then allocate with ties building up
        for (int s = 0; s < LENGTH; s++) begin
            touch_v_i   = 1'b1;
            touch_idx_i = 3'(s);
            tick();
        end
        touch_v_i = 1'b0;
        for (int a = 0; a < 8; a++) begin
            do_alloc(4'($urandom_range(14) + 1), 1'b0, 1'b0, -1, 0, 1'b0, 0, lat);
        end

        // Randomized traffic: masks, touches, stalls, stray acks
        for (int a = 0; a < 40; a++) begin
            do_alloc(4'($urandom_range(14) + 1), 1'($urandom_range(1)), 1'b1, -1, 0,
                     1'($urandom_range(1)), int'($urandom_range(LENGTH - 1)), lat);
        end
`ifdef LRU_ALLOC_PERF_EN
        check("perf_alloc", perf_alloc_cnt_o, m_allocs);
        check("perf_wait", perf_wait_cnt_o, m_waits);
`endif

        // Reset asserted while an offer is pending
        req_i = 4'b1000;
        tick();
        req_i = '0;
        for (int n = 0; n < 50 && !alloc_v_o; n++) tick();
        check("t6_offer", alloc_v_o, 1);
        rst_n = 1'b0;
        #1;
        check("t6_alloc_v_async", alloc_v_o, 0);
        check("t6_busy_async", busy_o, 0);
        model_reset();
        @(posedge clk);
        #1;
        check("t6_no_gnt", gnt_o, 0);
        rst_n = 1'b1;
        #1;
        check("t6_no_gnt_after", gnt_o, 0);
        do_alloc(4'b0100, 1'b0, 1'b0, -1, 0, 1'b0, 0, lat);
        check("t6_victim_after_reset", m_vic, 7);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
